// File: rtl/collector_pkg.sv
// Shared types, default geometry and element addressing for the result collector.
// Matrix element (r,c) lives at bit offset (r*LANES+c)*DATA_W of the flat matrix bus.
package collector_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  localparam int unsigned DATA_W_DFLT = 32;
  localparam int unsigned LANES_DFLT  = 4;
  localparam int unsigned BEAT_W      = $clog2(LANES_DFLT);
  localparam int unsigned MAT_W       = LANES_DFLT * LANES_DFLT * DATA_W_DFLT;

  function automatic int unsigned elem_lsb(input int unsigned r,
                                           input int unsigned c,
                                           input int unsigned lanes,
                                           input int unsigned data_w);
    return (r * lanes + c) * data_w;
  endfunction

endpackage

// File: rtl/collector_bank.sv
// LANES x LANES element store; one beat writes a full row (or a column when
// RESULT_COLLECTOR_TRANSPOSE_EN is defined). Contents persist until overwritten.
module collector_bank
  import collector_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DFLT,
  parameter int unsigned LANES  = LANES_DFLT
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            wr_en,
  input  logic [$clog2(LANES)-1:0]        wr_idx,
  input  logic [LANES*DATA_W-1:0]         wr_data,
  output logic [LANES*LANES*DATA_W-1:0]   rd_data
);

  logic [LANES*LANES*DATA_W-1:0] mat_q;
  logic [LANES-1:0]              sel;

  always_comb begin
    sel = '0;
    if (wr_en) sel[wr_idx] = 1'b1;
  end

  // sel picks the row (or column) receiving this beat; lane k lands in slot k of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mat_q <= '0;
    end else begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (sel[i]) begin
          for (int unsigned k = 0; k < LANES; k++) begin
`ifdef RESULT_COLLECTOR_TRANSPOSE_EN
            mat_q[elem_lsb(k, i, LANES, DATA_W) +: DATA_W] <= wr_data[k*DATA_W +: DATA_W];
`else
            mat_q[elem_lsb(i, k, LANES, DATA_W) +: DATA_W] <= wr_data[k*DATA_W +: DATA_W];
`endif
          end
        end
      end
    end
  end

  assign rd_data = mat_q;

endmodule

// File: rtl/result_collector.sv
// Collects LANES beats from the dispatcher into a square matrix and offers it on a
// valid/ready port; beats arriving while a matrix is held are dropped and flagged in ovf.
// Optional build macro: RESULT_COLLECTOR_TRANSPOSE_EN (beats fill columns instead of rows).
module result_collector
  import collector_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DFLT,
  parameter int unsigned LANES  = LANES_DFLT
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic                            in_valid,
  input  logic [DATA_W-1:0]               d1,
  input  logic [DATA_W-1:0]               d2,
  input  logic [DATA_W-1:0]               d3,
  input  logic [DATA_W-1:0]               d4,
  output logic                            in_ready,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [LANES*LANES*DATA_W-1:0]   m_out,
  output logic [$clog2(LANES)-1:0]        beat_idx,
  output logic                            ovf
);

  localparam int unsigned BW = $clog2(LANES);
  localparam logic [BW-1:0] LAST_BEAT = BW'(LANES - 1);

  state_t            state_q, state_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic              ovf_q, ovf_d;
  logic              wr_en;
  logic [LANES*DATA_W-1:0] lane_data;

  assign lane_data = {d4, d3, d2, d1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      beat_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      ovf_q   <= ovf_d;
    end
  end

  // Flush overrides everything, including a beat presented in the same cycle.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    ovf_d   = ovf_q;
    wr_en   = 1'b0;
    if (flush) begin
      state_d = COLLECT;
      beat_d  = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        COLLECT: begin
          if (in_valid) begin
            wr_en = 1'b1;
            if (beat_q == LAST_BEAT) begin
              beat_d  = '0;
              state_d = HOLD;
            end else begin
              beat_d = beat_q + BW'(1);
            end
          end
        end
        HOLD: begin
          if (in_valid) ovf_d = 1'b1;
          if (m_ready)  state_d = COLLECT;
        end
        default: state_d = COLLECT;
      endcase
    end
  end

  collector_bank #(
    .DATA_W (DATA_W),
    .LANES  (LANES)
  ) u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_idx  (beat_q),
    .wr_data (lane_data),
    .rd_data (m_out)
  );

  assign in_ready = (state_q == COLLECT);
  assign m_valid  = (state_q == HOLD);
  assign beat_idx = beat_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector: fill, gaps, backpressure, flush, back-to-back, reset.
module tb_result_collector;

  logic         clk = 1'b0;
  logic         rst_n, flush, in_valid, m_ready;
  logic [31:0]  d1, d2, d3, d4;
  logic         in_ready, m_valid, ovf;
  logic [511:0] m_out;
  logic [1:0]   beat_idx;

  int n_cmp = 0;
  int n_err = 0;
  logic [511:0] snap;

  result_collector #(.DATA_W(32), .LANES(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .d1       (d1),
    .d2       (d2),
    .d3       (d3),
    .d4       (d4),
    .in_ready (in_ready),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_out    (m_out),
    .beat_idx (beat_idx),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Bit offset of the element that beat b, lane k must land in.
  function automatic int unsigned pos(input int unsigned b, input int unsigned k);
`ifdef RESULT_COLLECTOR_TRANSPOSE_EN
    return (k * 4 + b) * 32;
`else
    return (b * 4 + k) * 32;
`endif
  endfunction

  // Element for beat b, lane k was driven as base + 4*b + k (b counted within the matrix).
  task automatic chk_mat(input string tag, input int unsigned base);
    for (int unsigned b = 0; b < 4; b++)
      for (int unsigned k = 0; k < 4; k++)
        chk($sformatf("%s_b%0d_k%0d", tag, b, k), 512'(m_out[pos(b, k) +: 32]), 512'(base + 4*b + k));
  endtask

  task automatic drive(input logic v, input int unsigned base);
    in_valid = v;
    d1 = base;
    d2 = base + 1;
    d3 = base + 2;
    d4 = base + 3;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; m_ready = 1'b0;
    d1 = '0; d2 = '0; d3 = '0; d4 = '0;
    #12;
    chk("rst_mvalid", 512'(m_valid), 512'(0));
    chk("rst_ovf", 512'(ovf), 512'(0));
    chk("rst_beat", 512'(beat_idx), 512'(0));
    chk("rst_mout", m_out, '0);
    step();
    rst_n = 1'b1;
    step();
    chk("rel_inready", 512'(in_ready), 512'(1));

    // Fill: beat b carries 4b..4b+3
    for (int unsigned b = 0; b < 4; b++) begin
      drive(1'b1, 4*b);
      step();
      if (b == 2) begin
        chk("fill_mvalid_early", 512'(m_valid), 512'(0));
        chk("fill_beat3", 512'(beat_idx), 512'(3));
      end
    end
    drive(1'b0, 0);
    chk("fill_mvalid", 512'(m_valid), 512'(1));
    chk("fill_inready", 512'(in_ready), 512'(0));
    chk("fill_beatwrap", 512'(beat_idx), 512'(0));
    chk_mat("fill", 0);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    chk("fill_release", 512'(m_valid), 512'(0));
    chk("fill_keep", 512'(m_out[pos(3, 3) +: 32]), 512'(15));

    // Gapped: 1,0,0,1,1,0,1 ; idle cycles present junk that must be ignored
    begin
      logic [6:0] pat;
      int unsigned got;
      pat = 7'b1011001;
      got = 0;
      for (int unsigned i = 0; i < 7; i++) begin
        if (pat[i]) begin
          drive(1'b1, 100 + 4*got);
          got++;
        end else begin
          drive(1'b0, 32'hDEAD0000);
        end
        step();
        chk($sformatf("gap_mvalid_%0d", i), 512'(m_valid), 512'(got == 4));
      end
    end
    drive(1'b0, 0);
    chk_mat("gap", 100);
    snap = m_out;

    // Backpressure: held matrix must not move, beats dropped
    in_valid = 1'b1; d1 = 32'h3f800000; d2 = '0; d3 = '0; d4 = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      step();
      chk($sformatf("bp_mout_%0d", i), m_out, snap);
      chk($sformatf("bp_inready_%0d", i), 512'(in_ready), 512'(0));
    end
    chk("bp_ovf", 512'(ovf), 512'(1));
    in_valid = 1'b0;
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    chk("bp_collect", 512'(in_ready), 512'(1));
    chk("bp_ovf_sticky", 512'(ovf), 512'(1));

    // Flush after 2 beats; concurrent beat ignored
    drive(1'b1, 200); step();
    drive(1'b1, 204); step();
    chk("fl_pre_beat", 512'(beat_idx), 512'(2));
    drive(1'b1, 32'hBAD0); flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_beat", 512'(beat_idx), 512'(0));
    chk("fl_ovf", 512'(ovf), 512'(0));
    chk("fl_mvalid", 512'(m_valid), 512'(0));
    for (int unsigned b = 0; b < 4; b++) begin
      drive(1'b1, 300 + 4*b);
      step();
    end
    drive(1'b0, 0);
    chk("fl_new_mvalid", 512'(m_valid), 512'(1));
    chk_mat("fl_new", 300);
    // Flush while holding discards the matrix but keeps the data
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_hold_mvalid", 512'(m_valid), 512'(0));
    chk("fl_hold_data", 512'(m_out[pos(1, 2) +: 32]), 512'(306));

    // Back-to-back with m_ready tied high: beat 4 lands in HOLD and is dropped
    m_ready = 1'b1;
    for (int unsigned j = 0; j < 9; j++) begin
      drive(1'b1, 400 + 4*j);
      step();
      if (j == 3) begin
        chk("b2b_m1_valid", 512'(m_valid), 512'(1));
        chk_mat("b2b_m1", 400);
      end
      if (j == 4) begin
        chk("b2b_drop_mvalid", 512'(m_valid), 512'(0));
        chk("b2b_drop_ovf", 512'(ovf), 512'(1));
        chk("b2b_drop_beat", 512'(beat_idx), 512'(0));
      end
    end
    drive(1'b0, 0);
    m_ready = 1'b0;
    chk("b2b_m2_valid", 512'(m_valid), 512'(1));
    chk_mat("b2b_m2", 420);
    chk("b2b_ovf", 512'(ovf), 512'(1));

    // Asynchronous reset while holding, away from any clock edge
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_mvalid", 512'(m_valid), 512'(0));
    chk("mid_rst_ovf", 512'(ovf), 512'(0));
    chk("mid_rst_beat", 512'(beat_idx), 512'(0));
    chk("mid_rst_mout", m_out, '0);
    step();
    rst_n = 1'b1;
    step();
    chk("mid_rel_inready", 512'(in_ready), 512'(1));
    drive(1'b1, 500);
    step();
    drive(1'b0, 0);
    chk("mid_rel_beat", 512'(beat_idx), 512'(1));
    chk("mid_rel_elem", 512'(m_out[pos(0, 3) +: 32]), 512'(503));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
